ucie_ctl_sb_parity_engine: RTL and testbench

Store-and-forward parity engine for sideband packets. It accepts a packet as a stream of PHASE_W-bit phases over a valid/ready interface and accumulates control parity (CP) and data parity (DP) on the fly. In generate mode it inserts CP/DP into the header; in check mode it compares them against the received header. It sits between the sideband packet assembler and the serializer (TX), or between the deserializer and the decoder (RX), and supersedes the combinational, fixed-4-phase parity generator.

---
 rtl/ucie_ctl_sb_parity_engine_pkg.sv | 20 ++
 rtl/ucie_ctl_sb_parity_engine_if.sv | 30 +++
 rtl/ucie_ctl_sb_parity_engine_phase_buffer.sv | 74 +++++++
 rtl/ucie_ctl_sb_parity_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_ucie_ctl_sb_parity_engine.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ucie_ctl_sb_parity_engine_pkg.sv
// rtl/ucie_ctl_sb_parity_engine_pkg.sv - shared defaults, mode and state types for the sideband parity engine
package ucie_ctl_sb_pkg;

  localparam int SB_PHASE_W         = 32;
  localparam int SB_MAX_DATA_PHASES = 2;
  localparam int SB_DP_BIT          = 31;
  localparam int SB_CP_BIT          = 30;

  typedef enum logic {
    SB_PAR_GEN = 1'b0,
    SB_PAR_CHK = 1'b1
  } sb_mode_e;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    DROP    = 2'd2
  } sb_state_e;

endpackage

// File: rtl/ucie_ctl_sb_parity_engine_if.sv
// rtl/ucie_ctl_sb_parity_engine_if.sv - input/output phase stream bundle for the sideband parity engine
interface ucie_ctl_sb_parity_engine_if
  import ucie_ctl_sb_pkg::*;
#(
  parameter int PHASE_W = SB_PHASE_W
) ();

  logic               in_valid;
  logic               in_ready;
  logic [PHASE_W-1:0] in_data;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [PHASE_W-1:0] out_data;
  logic               out_last;

  // Upstream source / downstream sink side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Engine side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/ucie_ctl_sb_parity_engine_phase_buffer.sv
// rtl/ucie_ctl_sb_parity_engine_phase_buffer.sv - store-and-forward phase storage with pointers, count and clear
module ucie_ctl_sb_phase_buffer
  import ucie_ctl_sb_pkg::*;
#(
  parameter int PHASE_W = SB_PHASE_W,
  parameter int DEPTH   = 2 + SB_MAX_DATA_PHASES,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_wr_en,
  input  logic [PHASE_W-1:0] i_wr_data,
  input  logic               i_rd_en,
  output logic [PHASE_W-1:0] o_rd_data,
  output logic [AW-1:0]      o_rd_ptr,
  output logic [CW-1:0]      o_count
);

  logic [PHASE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  // Next pointer and occupancy values; clear wins over any access
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_wr_en) begin
        wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (i_rd_en) begin
        rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      case ({i_wr_en, i_rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Phase storage; contents are only meaningful below the write pointer
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[rd_ptr_q];
  assign o_rd_ptr  = rd_ptr_q;
  assign o_count   = count_q;

endmodule

// File: rtl/ucie_ctl_sb_parity_engine.sv
// rtl/ucie_ctl_sb_parity_engine.sv - store-and-forward CP/DP generate/check engine; check mode under UCIE_CTL_SB_PARITY_CHECK_EN
module ucie_ctl_sb_parity_engine
  import ucie_ctl_sb_pkg::*;
#(
  parameter int PHASE_W         = SB_PHASE_W,
  parameter int MAX_DATA_PHASES = SB_MAX_DATA_PHASES,
  parameter int DP_BIT          = SB_DP_BIT,
  parameter int CP_BIT          = SB_CP_BIT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_mode,
  ucie_ctl_sb_parity_engine_if.slave    sb,
  output logic                          o_cp,
  output logic                          o_dp,
  output logic [1:0]                    o_par_err,
  output logic                          o_len_err
);

  localparam int DEPTH = 2 + MAX_DATA_PHASES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = $clog2(DEPTH + 1);

  // Header phase 1 minus the two parity slots
  localparam logic [PHASE_W-1:0] HDR1_MASK =
    ~((PHASE_W'(1) << DP_BIT) | (PHASE_W'(1) << CP_BIT));

  sb_state_e          state_q;
  sb_mode_e           mode_q;
  sb_mode_e           mode_in;
  logic [BW-1:0]      beat_cnt_q;
  logic               cp_acc_q, cp_acc_d;
  logic               dp_acc_q, dp_acc_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic [PHASE_W-1:0] out_data_q;
  logic               cp_q, dp_q;
  logic               len_err_q;

  logic               accept;
  logic               col_beat;
  logic               is_overflow;
  logic               legal_len;
  logic               emit_entry;
  logic               emit_pop;
  logic               emit_done;

  logic               buf_clear;
  logic               buf_wr;
  logic               buf_rd;
  logic [PHASE_W-1:0] buf_rd_data;
  logic [AW-1:0]      buf_rd_ptr;
  logic [CW-1:0]      buf_count;
  logic [PHASE_W-1:0] replay_data;

`ifdef UCIE_CTL_SB_PARITY_CHECK_EN
  logic               rx_cp_q, rx_cp_d;
  logic               rx_dp_q, rx_dp_d;
  logic [1:0]         par_err_q;
  assign mode_in = sb_mode_e'(i_mode);
`else
  logic               mode_unused;
  assign mode_unused = i_mode;
  assign mode_in     = SB_PAR_GEN;
`endif

  assign accept      = sb.in_valid & sb.in_ready;
  assign col_beat    = accept && (state_q == COLLECT);
  assign is_overflow = (beat_cnt_q == BW'(DEPTH));
  // Legal totals are even and the overflow index is even too, so odd index == legal
  assign legal_len   = beat_cnt_q[0];
  assign emit_entry  = col_beat && sb.in_last && legal_len;
  assign emit_pop    = (state_q == EMIT) && sb.out_ready && !out_last_q;
  assign emit_done   = (state_q == EMIT) && sb.out_ready && out_last_q;

  assign buf_wr    = col_beat && !is_overflow;
  assign buf_rd    = emit_entry || emit_pop;
  assign buf_clear = (col_beat && sb.in_last && !legal_len) ||
                     (col_beat && !sb.in_last && is_overflow) ||
                     emit_done;

  ucie_ctl_sb_phase_buffer #(
    .PHASE_W (PHASE_W),
    .DEPTH   (DEPTH)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (buf_clear),
    .i_wr_en   (buf_wr),
    .i_wr_data (sb.in_data),
    .i_rd_en   (buf_rd),
    .o_rd_data (buf_rd_data),
    .o_rd_ptr  (buf_rd_ptr),
    .o_count   (buf_count)
  );

  function automatic logic [PHASE_W-1:0] insert_par(input logic [PHASE_W-1:0] d,
                                                    input logic dp, input logic cp);
    logic [PHASE_W-1:0] r;
    r         = d;
    r[DP_BIT] = dp;
    r[CP_BIT] = cp;
    return r;
  endfunction

  // Running CP/DP; beat 0 restarts both so nothing carries over between packets
  always_comb begin
    cp_acc_d = cp_acc_q;
    dp_acc_d = dp_acc_q;
    if (col_beat) begin
      if (beat_cnt_q == BW'(0)) begin
        cp_acc_d = ^sb.in_data[31:0];
        dp_acc_d = 1'b0;
      end else if (beat_cnt_q == BW'(1)) begin
        cp_acc_d = cp_acc_q ^ (^(sb.in_data & HDR1_MASK));
      end else begin
        dp_acc_d = dp_acc_q ^ (^sb.in_data);
      end
    end
  end

`ifdef UCIE_CTL_SB_PARITY_CHECK_EN
  // Received parity bits, captured from header phase 1
  always_comb begin
    rx_cp_d = rx_cp_q;
    rx_dp_d = rx_dp_q;
    if (col_beat && (beat_cnt_q == BW'(1))) begin
      rx_cp_d = sb.in_data[CP_BIT];
      rx_dp_d = sb.in_data[DP_BIT];
    end
  end

  // Check result pulse at EMIT entry
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rx_cp_q   <= 1'b0;
      rx_dp_q   <= 1'b0;
      par_err_q <= 2'b00;
    end else begin
      rx_cp_q   <= rx_cp_d;
      rx_dp_q   <= rx_dp_d;
      par_err_q <= 2'b00;
      if (emit_entry && (mode_q == SB_PAR_CHK)) begin
        par_err_q <= {rx_dp_d != dp_acc_d, rx_cp_d != cp_acc_d};
      end
    end
  end

  assign o_par_err = par_err_q;
`else
  assign o_par_err = 2'b00;
`endif

  // Phase 1 carries the computed parity only when generating
  always_comb begin
    replay_data = buf_rd_data;
    if ((mode_q == SB_PAR_GEN) && (buf_rd_ptr == AW'(1))) begin
      replay_data = insert_par(buf_rd_data, dp_q, cp_q);
    end
  end

  // Packet FSM: collect, replay or discard, with registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= COLLECT;
      mode_q      <= SB_PAR_GEN;
      beat_cnt_q  <= '0;
      cp_acc_q    <= 1'b0;
      dp_acc_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      cp_q        <= 1'b0;
      dp_q        <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      cp_acc_q  <= cp_acc_d;
      dp_acc_q  <= dp_acc_d;
      len_err_q <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            if (beat_cnt_q == BW'(0)) begin
              mode_q <= mode_in;
            end
            if (sb.in_last) begin
              beat_cnt_q <= '0;
              if (legal_len) begin
                state_q     <= EMIT;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                out_data_q  <= buf_rd_data;
                cp_q        <= cp_acc_d;
                dp_q        <= dp_acc_d;
              end else begin
                len_err_q <= 1'b1;
              end
            end else if (is_overflow) begin
              state_q    <= DROP;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end
        end
        EMIT: begin
          if (sb.out_ready) begin
            if (out_last_q) begin
              state_q     <= COLLECT;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              out_data_q <= replay_data;
              out_last_q <= (buf_count == CW'(1));
            end
          end
        end
        DROP: begin
          if (accept && sb.in_last) begin
            state_q   <= COLLECT;
            len_err_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= COLLECT;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign sb.in_ready  = in_ready_q & i_rst;
  assign sb.out_valid = out_valid_q;
  assign sb.out_data  = out_data_q;
  assign sb.out_last  = out_last_q;
  assign o_cp         = cp_q;
  assign o_dp         = dp_q;
  assign o_len_err    = len_err_q;

endmodule

// File: tb/tb_ucie_ctl_sb_parity_engine.sv
// tb/tb_ucie_ctl_sb_parity_engine.sv - self-checking bench for the sideband parity engine
module tb_ucie_ctl_sb_parity_engine;

`ifdef UCIE_CTL_SB_PARITY_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int MAXLEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       o_cp, o_dp, o_len_err;
  logic [1:0] o_par_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  logic        last_q[$];
  logic        hold_cp, hold_dp;

  ucie_ctl_sb_parity_engine_if #(.PHASE_W(32)) sb ();

  ucie_ctl_sb_parity_engine dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_mode    (mode),
    .sb        (sb),
    .o_cp      (o_cp),
    .o_dp      (o_dp),
    .o_par_err (o_par_err),
    .o_len_err (o_len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit odd_ones(input logic [31:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic run_pkt(input bit md, input int stall_at, input int stall_len);
    int n, idx, outs, cyc, last_acc, first_vld, stall_left, lerr_n, perr_n, lerr_cyc, perr_cyc;
    logic [1:0]  perr_val, exp_perr;
    logic [31:0] held, exp_b;
    logic        held_last, exp_cp, exp_dp;
    bit          done, holding, legal, gen;
    n = in_q.size();
    idx = 0; outs = 0; cyc = 0; last_acc = -1; first_vld = -1;
    stall_left = stall_len; lerr_n = 0; perr_n = 0; lerr_cyc = -1; perr_cyc = -1;
    perr_val = 2'b00; held = '0; held_last = 1'b0; done = 0; holding = 0;
    out_q.delete();
    last_q.delete();
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (sb.out_valid && first_vld < 0) first_vld = cyc;
      if (o_len_err) begin lerr_n++; lerr_cyc = cyc; end
      if (o_par_err != 2'b00) begin perr_n++; perr_cyc = cyc; perr_val = o_par_err; end
      if (holding) begin
        chk("bp_data_stable", sb.out_data, held);
        chk("bp_last_stable", {31'd0, sb.out_last}, {31'd0, held_last});
        holding = 0;
      end
      if (sb.out_valid) chk("no_overlap_in_ready", {31'd0, sb.in_ready}, 32'd0);
      if (idx == n && last_acc >= 0 && cyc >= last_acc + 2 && !sb.out_valid) begin
        done = 1;
        sb.in_valid = 1'b0;
        sb.in_last  = 1'b0;
      end else begin
        if (idx < n) begin
          sb.in_valid = 1'b1;
          sb.in_data  = in_q[idx];
          sb.in_last  = (idx == n - 1);
          mode        = (idx == 0) ? md : 1'($urandom);
        end else begin
          sb.in_valid = 1'b0;
          sb.in_last  = 1'b0;
        end
        if (sb.out_valid && outs == stall_at && stall_left > 0) begin
          sb.out_ready = 1'b0;
          stall_left--;
        end else begin
          sb.out_ready = 1'b1;
        end
        if (sb.out_valid && sb.out_ready) begin
          out_q.push_back(sb.out_data);
          last_q.push_back(sb.out_last);
          outs++;
        end else if (sb.out_valid) begin
          holding   = 1;
          held      = sb.out_data;
          held_last = sb.out_last;
        end
        if (sb.in_valid && sb.in_ready) begin
          if (sb.in_last) last_acc = cyc;
          idx++;
        end
        @(posedge clk);
        cyc++;
      end
    end
    chk("no_timeout", {31'd0, done}, 32'd1);

    legal  = (n >= 2) && (n % 2 == 0) && (n <= MAXLEN);
    gen    = !(md && CHK_EN);
    exp_cp = odd_ones(in_q[0]) ^ ((n > 1) ? odd_ones(in_q[n > 1 ? 1 : 0] & 32'h3FFF_FFFF) : 1'b0);
    exp_dp = 1'b0;
    for (int i = 2; i < n; i++) exp_dp ^= odd_ones(in_q[i]);
    exp_perr = 2'b00;
    chk("out_count", outs, legal ? n : 0);
    if (legal) begin
      for (int i = 0; i < n && i < out_q.size(); i++) begin
        exp_b = in_q[i];
        if (i == 1 && gen) begin
          exp_b[31] = exp_dp;
          exp_b[30] = exp_cp;
        end
        chk("out_data", out_q[i], exp_b);
        chk("out_last", {31'd0, last_q[i]}, (i == n - 1) ? 32'd1 : 32'd0);
      end
      chk("latency", first_vld, last_acc + 1);
      hold_cp = exp_cp;
      hold_dp = exp_dp;
      if (!gen) exp_perr = {in_q[1][31] != exp_dp, in_q[1][30] != exp_cp};
    end
    chk("o_cp", {31'd0, o_cp}, {31'd0, hold_cp});
    chk("o_dp", {31'd0, o_dp}, {31'd0, hold_dp});
    chk("len_err_cnt", lerr_n, legal ? 0 : 1);
    if (!legal) chk("len_err_cyc", lerr_cyc, last_acc + 1);
    chk("par_err_cnt", perr_n, (exp_perr != 2'b00) ? 1 : 0);
    if (exp_perr != 2'b00) begin
      chk("par_err_val", {30'd0, perr_val}, {30'd0, exp_perr});
      chk("par_err_cyc", perr_cyc, last_acc + 1);
    end
  endtask

  initial begin
    rst = 1'b0;
    mode = 1'b0;
    sb.in_valid = 1'b0;
    sb.in_data = '0;
    sb.in_last = 1'b0;
    sb.out_ready = 1'b1;
    hold_cp = 1'b0;
    hold_dp = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, sb.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, sb.out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, sb.out_last}, 32'd0);
    chk("rst_out_data", sb.out_data, 32'd0);
    chk("rst_cp", {31'd0, o_cp}, 32'd0);
    chk("rst_dp", {31'd0, o_dp}, 32'd0);
    chk("rst_par_err", {30'd0, o_par_err}, 32'd0);
    chk("rst_len_err", {31'd0, o_len_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, sb.in_ready}, 32'd1);

    // generate, 4 beats
    in_q = '{32'h0000_0001, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0001};
    run_pkt(1'b0, 9, 0);
    if (out_q.size() > 1) chk("gen4_phase1", out_q[1], 32'hC000_0003);
    chk("gen4_cp", {31'd0, o_cp}, 32'd1);
    chk("gen4_dp", {31'd0, o_dp}, 32'd1);

    // generate, header-only
    in_q = '{32'h0000_0000, 32'h0000_0000};
    run_pkt(1'b0, 9, 0);
    chk("hdr_cp", {31'd0, o_cp}, 32'd0);
    chk("hdr_dp", {31'd0, o_dp}, 32'd0);

    // check mode, 4 beats with wrong CP in header
    in_q = '{32'h0000_0001, 32'h8000_0003, 32'hFFFF_FFFF, 32'h0000_0001};
    run_pkt(1'b1, 9, 0);

    // illegal lengths: 3 beats, then 6 beats (drop), then a clean packet
    in_q = '{32'h1234_5678, 32'h0000_00FF, 32'hA5A5_A5A5};
    run_pkt(1'b0, 9, 0);
    in_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    run_pkt(1'b0, 9, 0);
    in_q = '{32'h0000_0007, 32'h0000_0010, 32'h0F0F_0000, 32'h0000_0001};
    run_pkt(1'b0, 9, 0);

    // backpressure mid-emit
    in_q = '{32'hDEAD_BEEF, 32'h0000_0003, 32'h1357_9BDF, 32'h2468_ACE0};
    run_pkt(1'b0, 1, 3);

    // reset after beat 1 of a packet
    @(negedge clk);
    sb.in_valid = 1'b1; sb.in_data = 32'h0000_0001; sb.in_last = 1'b0; mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sb.in_data = 32'h0000_0013;
    @(posedge clk);
    @(negedge clk);
    sb.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, sb.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, sb.in_ready}, 32'd0);
    chk("midrst_cp", {31'd0, o_cp}, 32'd0);
    rst = 1'b1;
    hold_cp = 1'b0;
    hold_dp = 1'b0;
    in_q = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000};
    run_pkt(1'b0, 9, 0);

    // randomized packets
    for (int p = 0; p < 30; p++) begin
      int len;
      len = $urandom_range(1, 7);
      in_q.delete();
      for (int b = 0; b < len; b++) in_q.push_back($urandom);
      run_pkt(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
